// File: rtl/bcd_pkg.sv
// Shared display codes and converter state type for the BCD scan display
// and the downstream 7-segment decoder.
package bcd_pkg;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    IDLE,
    CONV
  } dd_state_t;

  // Double-dabble correction: a digit of 5 or more would overflow on the next shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Sequential binary-to-BCD converter, one magnitude bit per cycle.
// done marks the final iteration; bcd carries the finished result during that cycle.
module bcd_double_dabble
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  dd_state_t        state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] mag_reg, mag_next;
  logic [BW-1:0]    scratch_reg, scratch_next;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = add3(scratch_reg[4*gi +: 4]);
    end
  endgenerate

  assign shifted = {adj[BW-2:0], mag_reg[WIDTH-1]};

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    mag_next     = mag_reg;
    scratch_next = scratch_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mag_next     = neg ? (~value + ONE) : value;
          scratch_next = '0;
          count_next   = '0;
          state_next   = CONV;
        end
      end
      CONV: begin
        scratch_next = shifted;
        mag_next     = mag_reg << 1;
        count_next   = count_reg + 1'b1;
        if (count_reg == LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      mag_reg     <= '0;
      scratch_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      mag_reg     <= mag_next;
      scratch_reg <= scratch_next;
    end
  end

  assign busy = (state_reg == CONV);
  assign done = busy && (count_reg == LAST);
  assign bcd  = shifted;

endmodule

// File: rtl/bcd_scan_display.sv
// Converts a binary value to BCD and time-multiplexes the digits plus an
// optional minus slot onto a shared 4-bit code bus with active-low anodes.
module bcd_scan_display
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int LZB    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [WIDTH-1:0]  value,
  input  logic              is_signed,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [3:0]        segments,
  output logic [DIGITS:0]   an
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = $clog2(DIGITS + 1);
  localparam logic [PW-1:0] LAST_DIGIT = PW'(DIGITS - 1);
  localparam logic [PW-1:0] SIGN_POS   = PW'(DIGITS);

  logic            dd_busy, dd_done, start;
  logic [BW-1:0]   dd_bcd;
  logic            pend_neg_reg;
  logic [BW-1:0]   disp_reg;
  logic            disp_neg_reg;
  logic            done_reg;
  logic [PW-1:0]   pos_reg, pos_next;
  logic [3:0]      seg_reg, seg_next;
  logic [DIGITS:0] an_reg, an_next;
  logic [DIGITS-1:0] lead_zero;

  assign start = load && !dd_busy;

  bcd_double_dabble #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) u_dd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .value(value),
    .neg  (is_signed & value[WIDTH-1]),
    .busy (dd_busy),
    .done (dd_done),
    .bcd  (dd_bcd)
  );

  // A digit is a leading zero when it and every more-significant digit are zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign lead_zero[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_top
        assign lead_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0);
      end else begin : g_mid
        assign lead_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
      end
    end
  endgenerate

  always_comb begin
    pos_next = pos_reg;
    seg_next = seg_reg;
    an_next  = an_reg;
    if (tick) begin
      if (pos_reg == SIGN_POS) begin
        pos_next = '0;
      end else if (pos_reg == LAST_DIGIT) begin
        pos_next = disp_neg_reg ? SIGN_POS : '0;
      end else begin
        pos_next = pos_reg + 1'b1;
      end

      seg_next = CODE_MINUS;
      for (int k = 0; k < DIGITS; k++) begin
        if (pos_next == PW'(k)) begin
          seg_next = ((LZB != 0) && lead_zero[k]) ? CODE_BLANK : disp_reg[4*k +: 4];
        end
      end
      for (int k = 0; k <= DIGITS; k++) begin
        an_next[k] = (pos_next != PW'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_neg_reg <= 1'b0;
      disp_reg     <= '0;
      disp_neg_reg <= 1'b0;
      done_reg     <= 1'b0;
      pos_reg      <= '0;
      seg_reg      <= 4'h0;
      an_reg       <= '1;
    end else begin
      if (start) begin
        pend_neg_reg <= is_signed & value[WIDTH-1];
      end
      if (dd_done) begin
        disp_reg     <= dd_bcd;
        disp_neg_reg <= pend_neg_reg;
      end
      done_reg <= dd_done;
      pos_reg  <= pos_next;
      seg_reg  <= seg_next;
      an_reg   <= an_next;
    end
  end

  assign busy     = dd_busy;
  assign done     = done_reg;
  assign segments = seg_reg;
  assign an       = an_reg;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: two instances (LZB=1 and LZB=0) share stimulus.
module tb_bcd_scan_display;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] value;
  logic       is_signed;
  logic       load;
  logic       busy, done, busy0, done0;
  logic [3:0] segments, segments0;
  logic [3:0] an, an0;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_scan_display #(.WIDTH(8), .DIGITS(3), .LZB(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .value(value), .is_signed(is_signed),
    .load(load), .busy(busy), .done(done), .segments(segments), .an(an)
  );

  bcd_scan_display #(.WIDTH(8), .DIGITS(3), .LZB(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .value(value), .is_signed(is_signed),
    .load(load), .busy(busy0), .done(done0), .segments(segments0), .an(an0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic convert(input logic [7:0] v, input logic s);
    int busy_cnt = 0;
    int cyc = 0;
    value = v; is_signed = s; load = 1'b1;
    step();
    load = 1'b0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      step();
      cyc++;
    end
    $display("load value=%0h signed=%0d busy_cycles=%0d done=%0d", v, s, busy_cnt, done);
    check("done_seen", done, 1);
    check("busy_cycles", busy_cnt, 8);
    check("busy_after_done", busy, 0);
    step();
    check("done_single", done, 0);
  endtask

  task automatic scan_check(input string name,
                            input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                            input logic neg);
    int t = 0;
    do begin
      pulse_tick();
      t++;
    end while (an != 4'b1110 && t < 8);
    check({name, " sync_an"}, an, 4'b1110);
    check({name, " d0"}, segments, a0);
    check({name, " d0_nolzb"}, segments0, b0);
    pulse_tick();
    check({name, " an1"}, an, 4'b1101);
    check({name, " d1"}, segments, a1);
    check({name, " d1_nolzb"}, segments0, b1);
    pulse_tick();
    check({name, " an2"}, an, 4'b1011);
    check({name, " d2"}, segments, a2);
    check({name, " d2_nolzb"}, segments0, b2);
    pulse_tick();
    if (neg) begin
      check({name, " an_sign"}, an, 4'b0111);
      check({name, " minus"}, segments, 4'hA);
      pulse_tick();
    end
    check({name, " wrap_an"}, an, 4'b1110);
    $display("scan %s done", name);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int extra;
    rst_n = 1'b0; tick = 1'b0; value = '0; is_signed = 1'b0; load = 1'b0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seg", segments, 4'h0);
    check("rst_an", an, 4'b1111);
    rst_n = 1'b1;
    step();

    convert(8'd255, 1'b0);
    scan_check("u255", 4'd5, 4'd5, 4'd2, 4'd5, 4'd5, 4'd2, 1'b0);

    convert(8'hFF, 1'b1);
    scan_check("s_m1", 4'd1, 4'hF, 4'hF, 4'd1, 4'd0, 4'd0, 1'b1);

    convert(8'h80, 1'b1);
    scan_check("s_m128", 4'd8, 4'd2, 4'd1, 4'd8, 4'd2, 4'd1, 1'b1);

    convert(8'h80, 1'b0);
    scan_check("u128", 4'd8, 4'd2, 4'd1, 4'd8, 4'd2, 4'd1, 1'b0);

    // load 37, then hammer load=99 throughout the conversion
    value = 8'd37; is_signed = 1'b0; load = 1'b1;
    step();
    value = 8'd99;
    busy_cnt = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      tick = (cyc == 2);
      step();
      tick = 1'b0;
      cyc++;
      if (cyc == 3) begin
        check("hold_old_an", an, 4'b1101);
        check("hold_old_seg", segments, 4'd2);
      end
    end
    load = 1'b0;
    $display("load value=25 with load=63 during busy: busy_cycles=%0d done=%0d", busy_cnt, done);
    check("ign_done_seen", done, 1);
    check("ign_busy_cycles", busy_cnt, 8);
    extra = 0;
    repeat (12) begin
      step();
      if (done) extra++;
    end
    check("ign_extra_done", extra, 0);
    check("ign_busy_idle", busy, 0);
    scan_check("u37", 4'd7, 4'd3, 4'hF, 4'd7, 4'd3, 4'd0, 1'b0);

    // reset during cycle 4 of a conversion
    value = 8'd200; is_signed = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_seg", segments, 4'h0);
    check("midrst_an", an, 4'b1111);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      step();
      if (done) extra++;
    end
    $display("reset mid-conversion: done pulses after=%0d", extra);
    check("midrst_no_done", extra, 0);

    convert(8'd42, 1'b0);
    scan_check("u42", 4'd2, 4'd4, 4'hF, 4'd2, 4'd4, 4'd0, 1'b0);

    convert(8'd5, 1'b0);
    scan_check("u5", 4'd5, 4'hF, 4'hF, 4'd5, 4'd0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Parametrised successor to the two-digit BCD scan driver. It accepts a WIDTH-bit binary value in unsigned or two's-complement mode and converts it to DIGITS BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits, plus an optional minus-sign slot, onto a shared 4-bit code bus with active-low anode selects. It sits between datapath result registers and the board's 7-segment decoder.

## Interface
- WIDTH, 8, binary input width (≥2)
- DIGITS, 3, BCD digit count; must satisfy 10^DIGITS ≥ 2^WIDTH
- LZB, 1, 1 = blank leading zeros (digit 0 never blanked)
- clk  in  1  system clock; one clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  scan strobe, one clk wide; advances the digit scan
- value  in  WIDTH  binary value to convert
- is_signed  in  1  1 = treat value as two's complement
- load  in  1  request conversion of value/is_signed
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; new result is on display
- segments  out  4  digit code: 0–9, 4'hA = minus, 4'hF = blank
- an  out  DIGITS+1  active-low one-hot anode; bit DIGITS = sign slot

## Operation
- Converter FSM states: IDLE, CONV.
- IDLE + load: latch magnitude and neg. neg = is_signed & value[WIDTH-1]. Magnitude = neg ? (~value + 1) : value, as a WIDTH-bit unsigned. Clear scratch BCD and set count = 0. Go to CONV; busy = 1.
- CONV, one bit per cycle: add 3 to every scratch digit ≥ 5, then shift left one place, taking the magnitude MSB into digit 0 LSB.
- After WIDTH iterations: copy scratch to the display register, copy neg to disp_neg, pulse done, return to IDLE.
- load is ignored while busy, including on the final CONV cycle.
- The display register holds the previous result for the whole conversion, so the display never shows a partial result.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH bits unsigned. No overflow case exists, given the DIGITS constraint.
- Scan counter pos covers 0..DIGITS and changes only on tick.
  - From pos < DIGITS-1: go to pos+1.
  - From pos = DIGITS-1: go to DIGITS if disp_neg, else go to 0.
  - From pos = DIGITS: go to 0.
- If pos = DIGITS and disp_neg has cleared, the next tick goes to 0.
- On tick, segments and an are registered from the new pos:
  - pos < DIGITS: segments = digit[pos], or 4'hF if LZB and the digit is a leading zero.
  - pos = DIGITS: segments = 4'hA.
  - an = ~(1 << pos).
- Leading zero: digit[k] with k > 0 where every digit[j], j ≥ k, is zero.

## Timing
- Reset values: busy 0, done 0, display digits 0, disp_neg 0, pos 0, segments 4'h0, an all ones (dark until the first tick).
- Latency: load sampled in cycle n → busy high in cycles n+1..n+WIDTH. On the edge ending cycle n+WIDTH, the display is updated, done is high for one cycle, and busy falls.
- Next load is accepted in the cycle after done.
- Display update and tick in the same cycle: segments/an use the display register as it was before that edge. The new value shows from the next tick.
- rst_n low mid-conversion aborts on that edge. All state returns to reset values; no done pulse.
- tick and load are independent and may coincide.

## Structure
- Shared package bcd_pkg holds CODE_MINUS = 4'hA and CODE_BLANK = 4'hF. The 7-segment decoder also needs these codes.
- The natural sub-module is bcd_double_dabble, which contains the converter FSM, count, and scratch register. Its interface is start/value/neg in and busy/done/bcd out.
- The top level holds the display register, LZB logic, and scan counter.

## Test plan
- WIDTH=8, DIGITS=3, unsigned 255 → busy for 8 cycles, done once. Scan over 3 ticks: 5 (an 4'b1110), 5 (4'b1101), 2 (4'b1011), then back to pos 0; sign slot never selected.
- Signed 8'hFF, LZB=1 → digits 1, F, F. Sign slot active with 4'hA on an 4'b0111; scan cycle length is 4 ticks.
- Signed 8'h80 → 8, 2, 1 and minus. Unsigned 8'h80 → 8, 2, 1, no sign slot.
- load 37, then load 99 asserted during busy → only 37 is displayed, single done. Old value remains on display until done.
- rst_n low at cycle 4 of a conversion → busy 0, no done, segments 0, an all ones. Subsequent load 42 converts normally.
- LZB=0, value 5 → digits 5, 0, 0 shown; LZB=1 → 5, F, F.
